// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: binary-coded-modulation scan controller for a 64x64 HUB75
// panel. It walks both halves of the sprite ROM (upper rows 0-31 on port 0,
// lower rows 32-63 on port 1), slices each 24-bit RGB pixel into bit planes
// and sequences the shift clock, latch strobe, output enable and row address.
//
// Optional feature: define HUB75_DEADTIME_EN to insert a 4-cycle blanking
// (DEAD) phase between every latch and the following display phase.
//
// Parameters:
//   BITS  bit planes per channel (1..8); plane b uses channel bit 8-BITS+b
//   UNIT  display cycles of plane 0; plane b displays UNIT<<b cycles
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   en               scan enable, sampled only at frame boundaries
//   rom_addr0/1      upper/lower half ROM addresses {half, row[4:0], col[5:0]}
//   rom_data0/1      ROM pixels 24'hRRGGBB, valid one cycle after the address
//   hub_rgb          {b1,g1,r1,b0,g0,r0} shift data
//   hub_clk          panel shift clock
//   hub_lat          latch strobe
//   hub_oe_n         output enable, active-low
//   hub_addr         panel row-pair address
//   frame_start      one-cycle pulse on the first cycle of every frame
module hub75_scan_ctrl #(
    parameter int unsigned BITS = 8,
    parameter int unsigned UNIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [11:0] rom_addr0,
    output logic [11:0] rom_addr1,
    input  logic [23:0] rom_data0,
    input  logic [23:0] rom_data1,
    output logic [5:0]  hub_rgb,
    output logic        hub_clk,
    output logic        hub_lat,
    output logic        hub_oe_n,
    output logic [4:0]  hub_addr,
    output logic        frame_start
);

    localparam int unsigned PW         = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int unsigned DMAX       = UNIT << (BITS - 1);
    localparam int unsigned DW         = $clog2(DMAX + 1);
    localparam int unsigned BIT_BASE   = 8 - BITS;
    localparam int unsigned SHIFT_LAST = 129;
    localparam logic [PW-1:0] PLANE_LAST = PW'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DEAD,
        S_DISPLAY
    } state_t;

    state_t        state;
    logic [4:0]    row;
    logic [PW-1:0] plane;
    logic [5:0]    col;
    logic [7:0]    sc;
    logic [DW-1:0] dcnt;
`ifdef HUB75_DEADTIME_EN
    logic [1:0]    dead_cnt;
`endif

    logic [2:0]    bit_sel_c;
    logic [7:0]    r0_c, g0_c, b0_c, r1_c, g1_c, b1_c;
    logic [5:0]    pixel_c;
    logic [DW-1:0] disp_len_c;
    logic          disp_done_c;
    logic          plane_last_c;
    logic [4:0]    next_row_c;

    // Plane bit selection and phase bookkeeping
    always_comb begin
        bit_sel_c    = 3'(BIT_BASE) + 3'(plane);
        r0_c         = rom_data0[23:16];
        g0_c         = rom_data0[15:8];
        b0_c         = rom_data0[7:0];
        r1_c         = rom_data1[23:16];
        g1_c         = rom_data1[15:8];
        b1_c         = rom_data1[7:0];
        pixel_c      = {b1_c[bit_sel_c], g1_c[bit_sel_c], r1_c[bit_sel_c],
                        b0_c[bit_sel_c], g0_c[bit_sel_c], r0_c[bit_sel_c]};
        disp_len_c   = DW'(UNIT) << plane;
        disp_done_c  = (dcnt == disp_len_c - DW'(1));
        plane_last_c = (plane == PLANE_LAST);
        // Row advances only after the last plane; 31 wraps to 0
        next_row_c   = plane_last_c ? row + 5'd1 : row;
    end

    // Scan sequencer with registered panel and ROM outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            sc          <= '0;
            dcnt        <= '0;
`ifdef HUB75_DEADTIME_EN
            dead_cnt    <= '0;
`endif
            rom_addr0   <= 12'h000;
            rom_addr1   <= 12'h800;
            hub_rgb     <= '0;
            hub_clk     <= 1'b0;
            hub_lat     <= 1'b0;
            hub_oe_n    <= 1'b1;
            hub_addr    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            hub_clk     <= 1'b0;
            hub_lat     <= 1'b0;

            case (state)
                S_IDLE: begin
                    hub_oe_n <= 1'b1;
                    if (en) begin
                        state       <= S_SHIFT;
                        row         <= '0;
                        plane       <= '0;
                        col         <= '0;
                        sc          <= '0;
                        rom_addr0   <= 12'h000;
                        rom_addr1   <= 12'h800;
                        frame_start <= 1'b1;
                    end
                end

                // Even cycles present column addresses, odd cycles capture
                // pixel bits; hub_clk rises two cycles after each capture.
                S_SHIFT: begin
                    if (sc[0]) begin
                        if (sc < 8'd128) begin
                            hub_rgb   <= pixel_c;
                            col       <= col + 6'd1;
                            rom_addr0 <= {1'b0, row, col + 6'd1};
                            rom_addr1 <= {1'b1, row, col + 6'd1};
                        end
                    end else if (sc >= 8'd2) begin
                        hub_clk <= 1'b1;
                    end
                    if (sc == 8'(SHIFT_LAST)) begin
                        state    <= S_LATCH;
                        hub_lat  <= 1'b1;
                        hub_addr <= row;
                    end
                    sc <= sc + 8'd1;
                end

                S_LATCH: begin
`ifdef HUB75_DEADTIME_EN
                    state    <= S_DEAD;
                    dead_cnt <= '0;
`else
                    state    <= S_DISPLAY;
                    hub_oe_n <= 1'b0;
                    dcnt     <= '0;
`endif
                end

`ifdef HUB75_DEADTIME_EN
                // Blank for 4 cycles after the latch to suppress ghosting
                S_DEAD: begin
                    dead_cnt <= dead_cnt + 2'd1;
                    if (dead_cnt == 2'd3) begin
                        state    <= S_DISPLAY;
                        hub_oe_n <= 1'b0;
                        dcnt     <= '0;
                    end
                end
`endif

                S_DISPLAY: begin
                    if (disp_done_c) begin
                        hub_oe_n <= 1'b1;
                        plane    <= plane_last_c ? '0 : plane + PW'(1);
                        row      <= next_row_c;
                        // en only matters once the last row's last plane ends
                        if (plane_last_c && (row == 5'd31) && !en) begin
                            state <= S_IDLE;
                        end else begin
                            state       <= S_SHIFT;
                            sc          <= '0;
                            col         <= '0;
                            rom_addr0   <= {1'b0, next_row_c, 6'd0};
                            rom_addr1   <= {1'b1, next_row_c, 6'd0};
                            frame_start <= plane_last_c && (row == 5'd31);
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
